// File: rtl/reference_buffer_reader_pkg.sv
// reference_buffer_reader_pkg: FSM state encoding and default widths shared by the reader, its interface and FIFO
package reference_buffer_reader_pkg;
   localparam int DEF_BUFFER_BITS = 8;
   localparam int DEF_I_BITS      = 12;
   localparam int DEF_Q_BITS      = 12;
   localparam int DEF_FIFO_DEPTH  = 4;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/reference_buffer_reader_if.sv
// reference_buffer_reader_if: window control, index-request, sample-return and output streams of the reader
interface reference_buffer_reader_if #(
   parameter int BUFFER_BITS = reference_buffer_reader_pkg::DEF_BUFFER_BITS,
   parameter int I_BITS      = reference_buffer_reader_pkg::DEF_I_BITS,
   parameter int Q_BITS      = reference_buffer_reader_pkg::DEF_Q_BITS
);
   logic                   start;
   logic [BUFFER_BITS-1:0] start_index;
   logic [BUFFER_BITS:0]   length;
   logic                   busy;
   logic                   done;
   logic                   m_axis_index_tvalid;
   logic [BUFFER_BITS-1:0] m_axis_index_tdata;
   logic                   m_axis_index_tready;
   logic                   s_axis_data_tvalid;
   logic                   s_axis_data_tready;
   logic [I_BITS-1:0]      i;
   logic [Q_BITS-1:0]      q;
   logic                   m_axis_tvalid;
   logic                   m_axis_tready;
   logic [I_BITS-1:0]      m_axis_i;
   logic [Q_BITS-1:0]      m_axis_q;
   logic                   m_axis_tlast;
   modport master (
      input  start, start_index, length, m_axis_index_tready, s_axis_data_tvalid, i, q, m_axis_tready,
      output busy, done, m_axis_index_tvalid, m_axis_index_tdata, s_axis_data_tready,
             m_axis_tvalid, m_axis_i, m_axis_q, m_axis_tlast
   );
   modport slave (
      output start, start_index, length, m_axis_index_tready, s_axis_data_tvalid, i, q, m_axis_tready,
      input  busy, done, m_axis_index_tvalid, m_axis_index_tdata, s_axis_data_tready,
             m_axis_tvalid, m_axis_i, m_axis_q, m_axis_tlast
   );
endinterface

// File: rtl/reference_buffer_reader_fifo.sv
// reference_buffer_reader_fifo: return-sample FIFO with synchronous push/pop and count/full/empty flags
module reference_buffer_reader_fifo
   import reference_buffer_reader_pkg::*;
#(
   parameter int WIDTH = DEF_I_BITS + DEF_Q_BITS,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_count;
   assign o_dout  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
   // storage is reset too so the presented head reads zero during reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else begin
         if (i_push) r_mem[r_wr] <= i_din;
         r_wr    <= r_wr + AW'(i_push);
         r_rd    <= r_rd + AW'(i_pop);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
endmodule

// File: rtl/reference_buffer_reader.sv
// reference_buffer_reader: streams a wrapping window of reference-buffer samples; REFERENCE_BUFFER_READER_STALL_CNT_EN adds stall_cnt
module reference_buffer_reader
   import reference_buffer_reader_pkg::*;
#(
   parameter int BUFFER_BITS = DEF_BUFFER_BITS,
   parameter int I_BITS      = DEF_I_BITS,
   parameter int Q_BITS      = DEF_Q_BITS,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic clk,
   input  logic rst_n,
`ifdef REFERENCE_BUFFER_READER_STALL_CNT_EN
   output logic [15:0] stall_cnt,
`endif
   reference_buffer_reader_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int LW = BUFFER_BITS + 1;
   state_t                   r_state;
   logic [BUFFER_BITS-1:0]   r_idx;
   logic [LW-1:0]            r_issue_left, r_out_left;
   logic [CW-1:0]            r_inflight;
   logic                     r_vld;
   logic                     w_hs, w_push, w_pop, w_full, w_empty;
   logic [CW-1:0]            w_count, w_inflight_nx, w_count_nx;
   logic [CW:0]              w_sum_nx;
   logic [LW-1:0]            w_issue_left_nx;
   logic [I_BITS+Q_BITS-1:0] w_head;
   // samples arriving while IDLE are leftovers of an aborted window and are dropped
   assign w_hs                    = r_vld & bus.m_axis_index_tready;
   assign bus.s_axis_data_tready  = rst_n & ~w_full;
   assign w_push                  = bus.s_axis_data_tvalid & bus.s_axis_data_tready & (r_state != IDLE);
   assign w_pop                   = ~w_empty & bus.m_axis_tready;
   assign w_inflight_nx           = r_inflight + CW'(w_hs) - CW'(w_push);
   assign w_count_nx              = w_count + CW'(w_push) - CW'(w_pop);
   assign w_sum_nx                = {1'b0, w_inflight_nx} + {1'b0, w_count_nx};
   assign w_issue_left_nx         = r_issue_left - LW'(w_hs);
   assign bus.busy                = r_state != IDLE;
   assign bus.done                = r_state == DONE;
   assign bus.m_axis_index_tvalid = r_vld;
   assign bus.m_axis_index_tdata  = r_idx;
   assign bus.m_axis_tvalid       = ~w_empty;
   assign {bus.m_axis_i, bus.m_axis_q} = w_head;
   assign bus.m_axis_tlast        = ~w_empty & (r_out_left == LW'(1));
   reference_buffer_reader_fifo #(.WIDTH(I_BITS + Q_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk, .rst_n, .i_push(w_push), .i_din({bus.i, bus.q}), .i_pop(w_pop),
      .o_dout(w_head), .o_count(w_count), .o_full(w_full), .o_empty(w_empty)
   );
   // request valid is computed from next-cycle occupancy so it never drops once raised
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_issue_left <= '0;
         r_out_left   <= '0;
         r_inflight   <= '0;
         r_vld        <= 1'b0;
      end else begin
         r_inflight <= w_inflight_nx;
         case (r_state)
            IDLE: if (bus.start) begin
               r_state      <= bus.length == '0 ? DONE : ISSUE;
               r_idx        <= bus.start_index;
               r_issue_left <= bus.length;
               r_out_left   <= bus.length;
               r_vld        <= bus.length != '0;
            end
            ISSUE: begin
               r_state      <= w_issue_left_nx == '0 ? DRAIN : ISSUE;
               r_idx        <= r_idx + BUFFER_BITS'(w_hs);
               r_issue_left <= w_issue_left_nx;
               r_out_left   <= r_out_left - LW'(w_pop);
               r_vld        <= w_issue_left_nx != '0 && w_sum_nx < (CW+1)'(FIFO_DEPTH);
            end
            DRAIN: begin
               r_state    <= w_pop && r_out_left == LW'(1) ? DONE : DRAIN;
               r_out_left <= r_out_left - LW'(w_pop);
            end
            default: r_state <= IDLE;
         endcase
      end
`ifdef REFERENCE_BUFFER_READER_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_cnt <= '0;
      else if (r_state == IDLE && bus.start) stall_cnt <= '0;
      else if (~w_empty && !bus.m_axis_tready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_reference_buffer_reader.sv
// tb_reference_buffer_reader: randomized windows against a queue-based buffer and output model
module tb_reference_buffer_reader;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   reference_buffer_reader_if bus ();
`ifdef REFERENCE_BUFFER_READER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif
   reference_buffer_reader dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef REFERENCE_BUFFER_READER_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .bus(bus)
   );
   int n_tests = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, first_acc = 0, last_acc = 0, max_inflight = 0, stalls = 0, hold = 0;
   int p_idx = 100, p_resp = 100, p_out = 100;
   bit resp_en = 1'b1;
   logic [7:0]  pend[$], issued[$];
   logic [23:0] outs[$];
   bit          lasts[$];
   logic [23:0] ref_mem [256];
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // buffer responder and output monitor: inputs change at negedge, handshakes are resolved before the next posedge
   initial forever begin
      @(negedge clk);
      bus.m_axis_index_tready = $urandom_range(99) < p_idx;
      bus.s_axis_data_tvalid  = resp_en && pend.size() != 0 && $urandom_range(99) < p_resp;
      {bus.i, bus.q}          = pend.size() != 0 ? ref_mem[pend[0]] : 24'h0;
      if (hold != 0) begin
         bus.m_axis_tready = 1'b0;
         if (bus.m_axis_tvalid) hold--;
      end else bus.m_axis_tready = $urandom_range(99) < p_out;
      #1;
      if (bus.m_axis_tvalid && !bus.m_axis_tready) stalls++;
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.s_axis_data_tvalid && bus.s_axis_data_tready) void'(pend.pop_front());
      if (bus.m_axis_index_tvalid && bus.m_axis_index_tready) begin
         pend.push_back(bus.m_axis_index_tdata);
         issued.push_back(bus.m_axis_index_tdata);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         outs.push_back({bus.m_axis_i, bus.m_axis_q});
         lasts.push_back(bus.m_axis_tlast);
         if (outs.size() == 1) first_acc = cyc + 1;
         last_acc = cyc + 1;
      end
      if (issued.size() - outs.size() > max_inflight) max_inflight = issued.size() - outs.size();
   end
   function automatic int idx_err(input logic [7:0] s, input int len);
      int e = issued.size() != len;
      for (int k = 0; k < issued.size() && k < len; k++) if (issued[k] !== 8'(s + k)) e++;
      return e;
   endfunction
   function automatic int data_err(input logic [7:0] s, input int len);
      int e = outs.size() != len;
      for (int k = 0; k < outs.size() && k < len; k++) if (outs[k] !== ref_mem[8'(s + k)]) e++;
      return e;
   endfunction
   function automatic int last_err(input int len);
      int e = lasts.size() != len;
      for (int k = 0; k < lasts.size(); k++) if (lasts[k] != (k == len - 1)) e++;
      return e;
   endfunction
   task automatic clear_log;
      issued.delete();
      outs.delete();
      lasts.delete();
      done_cnt = 0;
      stalls = 0;
      max_inflight = 0;
   endtask
   task automatic pulse_start(input logic [7:0] s, input logic [8:0] len);
      @(negedge clk);
      bus.start = 1'b1;
      bus.start_index = s;
      bus.length = len;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic wait_done(output bit to);
      for (int n = 0; n < 3000 && done_cnt == 0; n++) @(negedge clk);
      to = done_cnt == 0;
      repeat (3) @(negedge clk);
   endtask
   task automatic test_reset;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.busy, bus.done, bus.m_axis_index_tvalid, bus.m_axis_index_tdata, bus.m_axis_tvalid,
           bus.m_axis_tlast, bus.m_axis_i, bus.m_axis_q, bus.s_axis_data_tready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b ivld=%b idx=%h ovld=%b last=%b i=%h q=%h srdy=%b, want all 0",
                  bus.busy, bus.done, bus.m_axis_index_tvalid, bus.m_axis_index_tdata, bus.m_axis_tvalid,
                  bus.m_axis_tlast, bus.m_axis_i, bus.m_axis_q, bus.s_axis_data_tready);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (bus.s_axis_data_tready !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: srdy=%b busy=%b, want srdy=1 busy=0", bus.s_axis_data_tready, bus.busy);
      end
   endtask
   task automatic test_basic;
      bit to;
      int e;
      clear_log();
      pulse_start(8'h10, 9'd4);
      wait_done(to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL basic_done: timeout, want done pulse"); end
      e = idx_err(8'h10, 4);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL basic_idx: %0d index errors, want 0", e); end
      e = data_err(8'h10, 4);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL basic_data: %0d sample errors, want 0", e); end
      e = last_err(4);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL basic_tlast: %0d tlast errors, want 0", e); end
      n_tests++;
      if (done_cnt != 1 || done_cyc != last_acc) begin
         n_fail++;
         $display("FAIL basic_done_timing: %0d pulses at cycle %0d, want 1 pulse at cycle %0d", done_cnt, done_cyc, last_acc);
      end
      n_tests++;
      if (last_acc - first_acc != 3) begin
         n_fail++;
         $display("FAIL basic_throughput: 4 samples over %0d cycles, want 3", last_acc - first_acc);
      end
   endtask
   task automatic test_wrap;
      bit to;
      int e;
      clear_log();
      pulse_start(8'hFE, 9'd4);
      wait_done(to);
      e = idx_err(8'hFE, 4) + data_err(8'hFE, 4) + int'(to);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL wrap: %0d errors (idx=%p), want 0 and FE FF 00 01", e, issued); end
   endtask
   task automatic test_len0;
      bit to;
      clear_log();
      pulse_start(8'($urandom), 9'd0);
      wait_done(to);
      n_tests++;
      if (to || done_cnt != 1 || issued.size() != 0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL len0: timeout=%b done=%0d requests=%0d busy=%b, want 0 1 0 0", to, done_cnt, issued.size(), bus.busy);
      end
   endtask
   task automatic test_busy_ignore;
      bit to;
      int e;
      clear_log();
      pulse_start(8'h40, 9'd4);
      pulse_start(8'h80, 9'd1);
      wait_done(to);
      e = idx_err(8'h40, 4) + data_err(8'h40, 4) + int'(to);
      n_tests++;
      if (e != 0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL busy_ignore: %0d errors, %0d done pulses, want 0 and 1", e, done_cnt);
      end
   endtask
   task automatic test_backpressure;
      bit to;
      int e;
      logic [7:0] s = 8'($urandom);
      clear_log();
      hold = 10;
      pulse_start(s, 9'd12);
      wait_done(to);
      e = idx_err(s, 12) + data_err(s, 12) + last_err(12) + int'(to);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL bp_data: %0d errors, want 0", e); end
      n_tests++;
      if (max_inflight > 4) begin n_fail++; $display("FAIL bp_inflight: %0d outstanding, want <= 4", max_inflight); end
      n_tests++;
      if (stalls != 10) begin n_fail++; $display("FAIL bp_stalls: %0d stall cycles seen, want 10", stalls); end
`ifdef REFERENCE_BUFFER_READER_STALL_CNT_EN
      n_tests++;
      if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d, want 10", stall_cnt); end
`endif
   endtask
   task automatic test_reset_midwindow;
      bit to;
      int e;
      clear_log();
      resp_en = 1'b0;
      pulse_start(8'h80, 9'd8);
      for (int n = 0; n < 50 && issued.size() < 2; n++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.busy, bus.done, bus.m_axis_index_tvalid, bus.m_axis_index_tdata, bus.m_axis_tvalid,
           bus.m_axis_tlast, bus.m_axis_i, bus.m_axis_q, bus.s_axis_data_tready} !== '0 || issued.size() != 2) begin
         n_fail++;
         $display("FAIL midreset_outputs: busy=%b ivld=%b idx=%h ovld=%b requests=%0d, want 0 0 00 0 2",
                  bus.busy, bus.m_axis_index_tvalid, bus.m_axis_index_tdata, bus.m_axis_tvalid, issued.size());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      resp_en = 1'b1;
      for (int n = 0; n < 50 && pend.size() != 0; n++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_tests++;
      if (pend.size() != 0 || outs.size() != 0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_discard: pending=%0d outputs=%0d busy=%b, want 0 0 0", pend.size(), outs.size(), bus.busy);
      end
      clear_log();
      pulse_start(8'h20, 9'd2);
      wait_done(to);
      e = idx_err(8'h20, 2) + data_err(8'h20, 2) + last_err(2) + int'(to);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL midreset_restart: %0d errors, want 0", e); end
   endtask
   task automatic test_random;
      bit to;
      int e, nl;
      logic [7:0] s;
      p_idx = 60;
      p_resp = 70;
      p_out = 50;
      for (int w = 0; w < 4; w++) begin
         int len = w == 0 ? 256 : int'($urandom_range(40, 1));
         s = 8'($urandom);
         clear_log();
         pulse_start(s, 9'(len));
         wait_done(to);
         nl = 0;
         foreach (lasts[k]) nl += int'(lasts[k]);
         e = idx_err(s, len) + data_err(s, len) + int'(to);
         n_tests++;
         if (e != 0) begin n_fail++; $display("FAIL random_data w%0d len %0d: %0d errors, want 0", w, len, e); end
         e = last_err(len);
         n_tests++;
         if (e != 0 || nl != 1) begin n_fail++; $display("FAIL random_tlast w%0d: %0d errors, %0d tlasts, want 0 and 1", w, e, nl); end
         n_tests++;
         if (max_inflight > 4) begin n_fail++; $display("FAIL random_inflight w%0d: %0d outstanding, want <= 4", w, max_inflight); end
      end
      p_idx = 100;
      p_resp = 100;
      p_out = 100;
   endtask
   initial begin
      bus.start = 1'b0;
      bus.start_index = '0;
      bus.length = '0;
      bus.m_axis_index_tready = 1'b0;
      bus.s_axis_data_tvalid = 1'b0;
      bus.i = '0;
      bus.q = '0;
      bus.m_axis_tready = 1'b0;
      for (int k = 0; k < 256; k++) ref_mem[k] = 24'($urandom);
      test_reset();
      test_basic();
      test_wrap();
      test_len0();
      test_busy_ignore();
      test_backpressure();
      test_reset_midwindow();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reference_buffer_reader.md
REFERENCE_BUFFER_READER -- requirements
Module: reference_buffer_reader

Interface
REQ-001 SHALL have parameter BUFFER_BITS, default 8: width of a reference-buffer index.
REQ-002 SHALL have parameter I_BITS, default 12: width of the I sample.
REQ-003 SHALL have parameter Q_BITS, default 12: width of the Q sample.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: return-FIFO depth and cap on in-flight requests (power of 2, at least 2).
REQ-005 SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a read window.
- start_index  in  BUFFER_BITS  first index of the window.
- length  in  BUFFER_BITS+1  samples in the window; 0 means none.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last sample is accepted downstream.
- m_axis_index_tvalid  out  1  index request valid.
- m_axis_index_tdata  out  BUFFER_BITS  requested index.
- m_axis_index_tready  in  1  buffer accepts the index.
- s_axis_data_tvalid  in  1  returned sample valid.
- s_axis_data_tready  out  1  reader can accept a returned sample.
- i  in  I_BITS  returned I sample.
- q  in  Q_BITS  returned Q sample.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  downstream accepts the output sample.
- m_axis_i  out  I_BITS  output I sample.
- m_axis_q  out  Q_BITS  output Q sample.
- m_axis_tlast  out  1  marks the last sample of the window.

Function
REQ-006 FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-007 Transitions:
- IDLE to ISSUE on start with length>0.
- ISSUE to DRAIN when the last index is accepted.
- DRAIN to DONE when the last sample is accepted downstream.
- DONE to IDLE after one cycle.
REQ-008 start with length=0 SHALL go IDLE to DONE directly (done pulse, no requests issued).
REQ-009 start SHALL be ignored while busy; start_index and length SHALL be registered when start is accepted.
REQ-010 Index requests SHALL follow the sequence start_index, start_index+1, and onward, modulo 2^BUFFER_BITS (wraps from 2^BUFFER_BITS-1 to 0).
REQ-011 m_axis_index_tvalid SHALL assert only in ISSUE and only when in-flight count plus FIFO occupancy is less than FIFO_DEPTH.
REQ-012 Once asserted, m_axis_index_tvalid SHALL stay high with tdata stable until accepted (tvalid and tready both high).
REQ-013 In-flight count SHALL increment on index acceptance and decrement on sample acceptance; on simultaneous events it SHALL be unchanged.
REQ-014 s_axis_data_tready SHALL be high whenever the FIFO is not full.
REQ-015 Returned samples SHALL be written to the FIFO in arrival order, which equals request order.
REQ-016 The output SHALL present the FIFO head.
- m_axis_tvalid SHALL equal "FIFO not empty".
- Data SHALL be held stable while tvalid is high and tready is low.
REQ-017 m_axis_tlast SHALL be high exactly on the sample numbered length within the window.
REQ-018 FIFO push and pop in the same cycle SHALL leave occupancy unchanged, with correct data ordering.
REQ-019 A full FIFO together with a stalled downstream SHALL apply back-pressure and SHALL lose no data.
REQ-020 Minimum latency from index acceptance to m_axis_tvalid SHALL be one cycle after the sample is accepted on s_axis_data.
REQ-021 Sustained throughput SHALL be one sample per cycle when all readies are high.

Reset
REQ-022 While rst_n is low, the following SHALL all be 0: FSM state (IDLE), counters, FIFO pointers, busy, done, m_axis_index_tvalid, m_axis_index_tdata, m_axis_tvalid, m_axis_tlast, m_axis_i and m_axis_q.
REQ-023 s_axis_data_tready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-024 Reset asserted mid-window SHALL abort immediately; samples still in flight after release SHALL be accepted and discarded while IDLE.

Configuration
REQ-025 With macro REFERENCE_BUFFER_READER_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits).
- It SHALL count cycles with m_axis_tvalid high and m_axis_tready low.
- It SHALL saturate at 16'hFFFF.
- It SHALL clear on an accepted start and on reset.
REQ-026 Without REFERENCE_BUFFER_READER_STALL_CNT_EN, the port and its logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the default widths (BUFFER_BITS, I_BITS, Q_BITS and FIFO_DEPTH).
REQ-028 The return FIFO SHALL be a separate sub-module, reference_buffer_reader_fifo, with synchronous push and pop and count/full/empty outputs.

Verification
REQ-029 Basic window: start_index=0x10, length=4, all readies high -> indices 0x10 to 0x13 issued, samples output in order, tlast on the 4th, done one cycle after.
REQ-030 Wrap: start_index=0xFE, length=4, BUFFER_BITS=8 -> indices 0xFE, 0xFF, 0x00, 0x01.
REQ-031 Back-pressure: m_axis_tready=0 for 10 cycles, FIFO_DEPTH=4 -> at most 4 indices in flight, no data loss, and stall_cnt=10 when the macro is defined.
REQ-032 length=0 -> no index requests issued, done pulses, busy low afterwards.
REQ-033 rst_n pulled low after 2 of 8 indices -> all outputs reach reset values asynchronously; a new start_index=0x20, length=2 then completes correctly.
REQ-034 Random tready on both the index and output channels, length=256 -> output sequence matches the buffer contents from start_index, exactly one tlast.
